link_rx_buffer: RTL and testbench

Receive-side stage of the req/ack byte link. It acts as the 4-phase handshake slave toward the link master and captures one byte per handshake into a small FIFO. It presents the bytes downstream on a valid/ready stream and raises a sticky `done` once a full burst has been accepted. It sits between the link's handshake wires and the consumer logic inside `link_top`.

---
 rtl/link_pkg.sv | 12 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/link_rx_buffer.sv | 96 +++++++++
 tb/tb_link_rx_buffer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Definitions shared by both ends of the req/ack byte link.
// Holds the handshake state encoding and the default link data width.
package link_pkg;

   localparam int LINK_DATA_W = 8;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } link_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO.
// Pushes are refused when full and pops are ignored when empty.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_occ;
   logic              w_push;
   logic              w_pop;

   assign full   = (r_occ == OCC_FULL);
   assign empty  = (r_occ == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign dout   = r_mem[r_rd_ptr];

   // Storage carries no reset; its contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_ONE;
            2'b01:   r_occ <= r_occ - OCC_ONE;
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: rtl/link_rx_buffer.sv
// Receive side of the req/ack byte link: 4-phase handshake slave feeding a
// FWFT FIFO, with a saturating byte count and a sticky burst-done flag.
module link_rx_buffer
   import link_pkg::*;
#(
   parameter int  DATA_W    = LINK_DATA_W,
   parameter int  DEPTH     = 4,
   parameter int  BURST_LEN = 4,
   localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [DATA_W-1:0] data_in,
   output logic              ack,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [CNT_W-1:0]  count,
   output logic              done
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   link_state_t      r_state;
   link_state_t      w_state_nxt;
   logic             r_ack;
   logic             w_ack_nxt;
   logic [CNT_W-1:0] r_count;
   logic             r_done;
   logic             w_push;
   logic             w_full;
   logic             w_empty;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (data_in),
      .pop   (m_ready),
      .dout  (m_data),
      .full  (w_full),
      .empty (w_empty)
   );

   // Full comes from registered occupancy, so a same-cycle pop does not
   // open space for a push until the following edge.
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req && !w_full && !r_done) begin
               w_push      = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            if (!req) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_ack_nxt = (w_state_nxt == S_ACK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         if (w_push && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
         end
         if (w_push && (r_count == CNT_LAST)) begin
            r_done <= 1'b1;
         end
      end
   end

   assign ack     = r_ack;
   assign count   = r_count;
   assign done    = r_done;
   assign m_valid = !w_empty;

endmodule

// File: tb/tb_link_rx_buffer.sv
// Bench for link_rx_buffer: directed handshake scenarios plus a randomized
// master/consumer, all checked every cycle against a queue-based model.
module tb_link_rx_buffer;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 4;
   localparam int BURST_LEN = 16;
   localparam int CNT_W     = $clog2(BURST_LEN + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              ack;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready = 1'b0;
   logic [CNT_W-1:0]  count;
   logic              done;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [DATA_W-1:0] q[$];
   int                mdl_count;
   bit                mdl_done;
   bit                mdl_hs;

   always #5 clk = ~clk;

   link_rx_buffer #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .BURST_LEN (BURST_LEN)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .data_in (data_in),
      .ack     (ack),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready),
      .count   (count),
      .done    (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mdl_count = 0;
      mdl_done  = 1'b0;
      mdl_hs    = 1'b0;
   endtask

   // One rising edge of the link, using the inputs present at that edge.
   task automatic model_edge();
      bit was_full;
      bit do_pop;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && m_ready;
      if (do_pop) void'(q.pop_front());
      if (!mdl_hs) begin
         if (req && !was_full && !mdl_done) begin
            q.push_back(data_in);
            mdl_hs = 1'b1;
            if (mdl_count < BURST_LEN) mdl_count++;
            if (mdl_count == BURST_LEN) mdl_done = 1'b1;
         end
      end else if (!req) begin
         mdl_hs = 1'b0;
      end
   endtask

   task automatic model_check();
      chk("ack", ack, mdl_hs);
      chk("m_valid", m_valid, q.size() != 0);
      if (q.size() != 0) chk("m_data", m_data, q[0]);
      chk("count", count, mdl_count);
      chk("done", done, mdl_done);
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      model_check();
   endtask

   // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_done", done, 0);
      model_reset();
      step();
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [DATA_W-1:0] b, input bit rdy);
      int n;
      req = 1'b1; data_in = b; m_ready = rdy;
      n = 0;
      do begin step(); n++; end while (!ack && n < 20);
      chk("hs_ack_seen", ack, 1);
      req = 1'b0;
      n = 0;
      do begin step(); n++; end while (ack && n < 20);
      chk("hs_ack_drop", ack, 0);
   endtask

   task automatic drain();
      int n;
      m_ready = 1'b1;
      n = 0;
      while (m_valid && n < 20) begin step(); n++; end
      chk("drain_empty", m_valid, 0);
      m_ready = 1'b0;
   endtask

   task automatic run_random(input int n_cycles, input int ready_pct, input int hold_max);
      int hold;
      hold = 0;
      for (int c = 0; c < n_cycles; c++) begin
         if (!req) begin
            data_in = DATA_W'($urandom);
            if (!ack && $urandom_range(99) < 60) begin
               req  = 1'b1;
               hold = $urandom_range(hold_max, 0);
            end
         end else if (ack) begin
            if (hold == 0) req = 1'b0;
            else hold--;
         end
         m_ready = ($urandom_range(99) < ready_pct);
         step();
         if ($urandom_range(299) == 0) async_reset();
      end
      req = 1'b0;
      async_reset();
   endtask

   initial begin
      model_reset();
      async_reset();

      // Single byte
      req = 1'b1; data_in = 8'hA5; m_ready = 1'b0;
      step();
      chk("single_ack", ack, 1);
      chk("single_valid", m_valid, 1);
      chk("single_data", m_data, 8'hA5);
      chk("single_count", count, 1);
      req = 1'b0;
      step();
      chk("single_ack_drop", ack, 0);
      drain();

      // Burst up to done, then further requests are ignored
      async_reset();
      for (int i = 0; i < BURST_LEN - 1; i++) send_byte(DATA_W'(8'h11 * ((i % 4) + 1)), 1'b1);
      chk("burst_not_done", done, 0);
      req = 1'b1; data_in = 8'h44; m_ready = 1'b1;
      step();
      chk("burst_done", done, 1);
      chk("burst_count", count, BURST_LEN);
      req = 1'b0;
      step();
      req = 1'b1; data_in = 8'h55;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_done_no_ack", ack, 0);
      end
      req = 1'b0;
      step();

      // Backpressure: full FIFO stalls the handshake
      async_reset();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      req = 1'b1; data_in = 8'h55;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("full_no_ack", ack, 0);
      end
      m_ready = 1'b1;
      step();
      chk("bp_pop_head", m_data, 8'h22);
      chk("bp_same_cycle_no_ack", ack, 0);
      m_ready = 1'b0;
      step();
      chk("bp_late_ack", ack, 1);
      chk("bp_count", count, 5);
      req = 1'b0;
      step();
      drain();

      // Simultaneous push and pop at occupancy 2
      async_reset();
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      req = 1'b1; data_in = 8'hA3; m_ready = 1'b1;
      step();
      chk("pp_ack", ack, 1);
      chk("pp_head", m_data, 8'hA2);
      req = 1'b0; m_ready = 1'b0;
      step();
      m_ready = 1'b1;
      step();
      chk("pp_order", m_data, 8'hA3);
      step();
      chk("pp_empty", m_valid, 0);
      m_ready = 1'b0;

      // Pointer wrap with 10 bytes
      async_reset();
      for (int i = 0; i < 10; i++) send_byte(DATA_W'($urandom), 1'($urandom_range(1)));
      drain();
      chk("wrap_count", count, 10);

      // Long req: one push regardless of hold time
      async_reset();
      req = 1'b1; data_in = 8'h3C; m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("long_ack_high", ack, 1);
      end
      chk("long_count", count, 1);
      req = 1'b0;
      step();
      chk("long_ack_drop", ack, 0);
      m_ready = 1'b1;
      step();
      chk("long_single_push", m_valid, 0);
      m_ready = 1'b0;

      // Reset mid-handshake with 3 bytes held
      async_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      req = 1'b1; data_in = 8'h77;
      step();
      chk("mid_ack", ack, 1);
      async_reset();
      step();
      chk("mid_fresh_ack", ack, 1);
      chk("mid_fresh_count", count, 1);
      chk("mid_fresh_data", m_data, 8'h77);
      req = 1'b0;
      step();

      // Randomized master and consumer
      async_reset();
      run_random(1500, 100, 3);
      run_random(1500, 50, 6);
      run_random(1500, 20, 2);
      run_random(1500, 0, 1);
      run_random(1500, 80, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
